// File: rtl/uart_rx_working.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling at a fixed
// clock divide, one-cycle valid / frame_err strobes.
module uart_rx_working #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] state_dbg
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic          rx_p;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  // Synchroniser plus one history flop for falling-edge detection; all idle high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          // Only a genuine 1->0 transition starts a frame; a held-low line does not.
          if (rx_p && !rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx            <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data_out <= shift_reg;
              valid    <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_working.sv
// Self-checking bench for uart_rx_working: directed scenarios plus random
// frames, scored against a pin-level frame/timing model.
module tb_uart_rx_working;

  localparam int CPB        = 10;
  localparam int HALF       = (CPB - 1) / 2;
  localparam int SYNC_LAG   = 2;
  localparam int STROBE_DLY = 2 + HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected strobes: {is_frame_err, byte} and the cycle each must appear in.
  logic [8:0] exp_q[$];
  int         cyc_q[$];
  logic [7:0] last_good = 8'h00;

  int hi_q[$];
  int lo_q[$];
  int hi_run = 0;
  int lo_run = 0;

  uart_rx_working #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] line;
    line = {stop_bit, b, 1'b0};
    exp_q.push_back({~stop_bit, b});
    cyc_q.push_back(cyc + SYNC_LAG + STROBE_DLY);
    for (int i = 0; i < 10; i++) begin
      rx = line[i];
      repeat (CPB) tick();
    end
  endtask

  task automatic send_break(input int nbits);
    exp_q.push_back({1'b1, 8'h00});
    cyc_q.push_back(cyc + SYNC_LAG + STROBE_DLY);
    rx = 1'b0;
    repeat (nbits * CPB) tick();
    rx = 1'b1;
  endtask

  // Drives 0xC3 up to the middle of data bit 4, then resets and idles the line.
  task automatic send_aborted(input logic [7:0] b);
    logic [9:0] line;
    line = {1'b1, b, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = line[i];
      repeat (CPB) tick();
    end
    rx = line[5];
    repeat (CPB / 2) tick();
    rst = 1'b1;
    rx  = 1'b1;
    tick();
    rst = 1'b0;
    last_good = 8'h00;
  endtask

  task automatic settle(input int n);
    rx = 1'b1;
    repeat (n) tick();
    check("missing_evt", exp_q.size(), 0);
  endtask

  // Monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) begin
        hi_run++;
        if (lo_run > 0) begin lo_q.push_back(lo_run); lo_run = 0; end
      end else begin
        lo_run++;
        if (hi_run > 0) begin hi_q.push_back(hi_run); hi_run = 0; end
      end
      if (valid || frame_err) begin
        check("strobe_excl", valid && frame_err, 0);
        if (exp_q.size() == 0) begin
          check("spurious_evt", exp_q.size(), 1);
        end else begin
          logic [8:0] ev;
          int         ecyc;
          ev   = exp_q.pop_front();
          ecyc = cyc_q.pop_front();
          check("evt_kind", frame_err, ev[8]);
          check("evt_cycle", cyc, ecyc);
          check("busy_at_evt", busy, 0);
          if (ev[8]) begin
            check("hold_data", data_out, last_good);
          end else begin
            check("rx_data", data_out, ev[7:0]);
            last_good = ev[7:0];
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    hi_q.delete();
    repeat (200) tick();
    check("quiet_runs", hi_q.size(), 0);
    check("quiet_busy", busy, 0);

    send_frame(8'hAA, 1'b1);
    settle(30);

    lo_q.delete();
    send_frame(8'h55, 1'b1);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    settle(30);
    check("b2b_rises", lo_q.size(), 3);
    for (int i = 1; i < 3; i++)
      if (i < lo_q.size()) check("b2b_gap", (lo_q[i] >= 1 && lo_q[i] <= 5), 1);

    hi_q.delete();
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    settle(30);
    check("glitch_runs", hi_q.size(), 1);
    if (hi_q.size() > 0) check("glitch_len", hi_q[0], HALF + 1);

    send_frame(8'h3C, 1'b0);
    settle(30);

    send_break(30);
    settle(30);
    send_frame(8'h81, 1'b1);
    settle(30);

    send_aborted(8'hC3);
    check("abort_data", data_out, 8'h00);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    settle(150);
    check("abort_data_hold", data_out, 8'h00);
    send_frame(8'h7E, 1'b1);
    settle(30);

    for (int n = 0; n < 12; n++) begin
      logic [7:0] b;
      logic       stop_ok;
      int         gap;
      b       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 7) != 0);
      send_frame(b, stop_ok);
      gap = stop_ok ? $urandom_range(0, 20) : $urandom_range(3, 20);
      rx = 1'b1;
      repeat (gap) tick();
    end
    settle(120);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_working.md
# uart_rx_working

Receive half of the UART pair: recovers 8N1 frames from the asynchronous serial line `rx` and presents each byte as a single-cycle `valid` strobe. Bit timing is a fixed clock divide (`CLKS_PER_BIT`), and data bits are sampled at mid-bit. It sits opposite the UART transmitter and shares its bit-time parameter, so a loopback of the transmitter's `tx` into `rx` must reproduce every transmitted byte.

## Interface
- `CLKS_PER_BIT`, 10, clock cycles per serial bit; legal values are ≥ 4. `HALF` = (`CLKS_PER_BIT`-1)/2, using integer division.
- `clk` input 1: the single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rx` input 1: serial line, idle high, asynchronous to `clk`.
- `data_out` output 8: last good byte received; LSB is the first data bit on the line.
- `valid` output 1: one-cycle pulse when `data_out` has been updated.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Synchronizer:** a 2-flop synchronizer on `rx` produces `rx_s`. A third flop holds `rx_p`, the previous value of `rx_s`. All three flops reset to 1.
- **Bit counter:** `cnt` is $clog2(`CLKS_PER_BIT`) bits wide. `bit_idx` is 3 bits. The shift register is 8 bits.
- **IDLE:** a falling edge (`rx_p`=1 and `rx_s`=0) moves to START with `cnt`=0. A line held low produces no edge, so it never starts a frame.
- **START:** `cnt` increments each cycle. At `cnt`==`HALF`:
  - if `rx_s`=0, go to DATA with `cnt`=0 and `bit_idx`=0;
  - otherwise it was a glitch: return to IDLE with no output.
- **DATA:** `cnt` increments each cycle. At `cnt`==`CLKS_PER_BIT`-1:
  - shift `rx_s` into bit `bit_idx` (LSB first), set `cnt`=0, increment `bit_idx`;
  - after the 8th bit (`bit_idx`==7), go to STOP.
- **STOP:** at `cnt`==`CLKS_PER_BIT`-1, sample `rx_s`:
  - if 1, copy the shift register to `data_out` and pulse `valid` on the next cycle;
  - if 0, pulse `frame_err` and leave `data_out` unchanged.
  - In both cases, go to IDLE immediately. This is mid-stop-bit, so a back-to-back start bit is accepted.
- `valid` and `frame_err` are never high in the same cycle.
- **Reset at any point (including mid-frame):**
  - state returns to IDLE; `cnt`, `bit_idx` and the shift register return to 0;
  - synchronizer flops return to 1;
  - `data_out`=0x00, `valid`=0, `frame_err`=0, `busy`=0;
  - a partial frame is discarded and produces no output.

## Timing
- Let S be the first cycle in which IDLE sees the falling edge on `rx_s`. `rx_s` lags the `rx` pin by 2 cycles.
- State is START from cycle S+1. The start bit is confirmed at S+1+`HALF`.
- Data bit k (k=1..8) is sampled at S+1+`HALF`+k·`CLKS_PER_BIT`.
- The stop bit is sampled at S+1+`HALF`+9·`CLKS_PER_BIT`.
- `valid` or `frame_err` is high in cycle S+2+`HALF`+9·`CLKS_PER_BIT`. For `CLKS_PER_BIT`=10 this is S+96.
- `busy` goes high at S+1. It goes low in the same cycle that `valid` or `frame_err` is high.
- `data_out` changes in the `valid` cycle and holds until the next `valid`.
- Tolerance: sampling is at mid-bit ±1 cycle, which tolerates ±4% baud mismatch at `CLKS_PER_BIT`=10.

## Test plan
All scenarios use `CLKS_PER_BIT`=10 and a 10 ns clock; the line is driven with ideal 8N1 frames unless stated.
- **Reset state:** assert `rst` for 2 cycles with `rx`=1, then release → `data_out`=0x00, `valid`=0, `frame_err`=0, `busy`=0; no activity for 200 cycles.
- **Single byte:** send 0xAA → exactly one `valid` pulse, 96 cycles after the `rx_s` falling edge, with `data_out`=0xAA and `frame_err`=0.
- **Back-to-back bytes:** send 0x55, 0x00, 0xFF with no idle gap → three `valid` pulses carrying those bytes in order; `busy` low for 1–5 cycles between frames.
- **Glitch rejection and framing error:**
  - a 3-cycle low pulse on `rx` → `busy` high for `HALF`+1 cycles, then IDLE; no `valid`, no `frame_err`.
  - a frame of 0x3C with its stop bit low → one `frame_err` pulse, no `valid`, `data_out` keeps its previous value.
- **Break condition:** hold `rx` low for 30 bit-times → exactly one `frame_err` pulse; no further activity until the line returns high and a new start bit arrives; a following 0x81 is received correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle during data bit 4 of 0xC3 → no `valid` or `frame_err` for that frame; `data_out`=0x00; a following clean 0x7E gives `valid` with `data_out`=0x7E.
